// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the word-only data-memory interface.
// Accepts load/store requests over valid/ready, performs word reads and
// writes to data_memory, extracts and extends byte/half loads, and merges
// sub-word stores with a read-modify-write sequence.
// Optional build macro LSU_RANGE_CHECK_EN: when defined, any request whose
// address lies beyond the attached memory is answered with an error and no
// access; when undefined, the word index wraps modulo MEM_WORDS.
module load_store_unit #(
  parameter int MEM_WORDS = 64,
  parameter int IDX_W     = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0]  SIZE_B   = 2'b00;
  localparam logic [1:0]  SIZE_H   = 2'b01;
  localparam logic [1:0]  SIZE_W   = 2'b10;
  localparam logic [31:0] IDX_MASK = 32'(MEM_WORDS - 1);

  // Pick the addressed lane out of a memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(
    input logic [31:0] word,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_B:  r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SIZE_H:  r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Merge right-justified store data into the addressed lane of a word.
  function automatic logic [31:0] merge_store(
    input logic [31:0] word,
    input logic [31:0] wdata,
    input logic [1:0]  off,
    input logic [1:0]  size
  );
    logic [31:0] m;
    m = word;
    case (size)
      SIZE_B: begin
        case (off)
          2'b00:   m[7:0]   = wdata[7:0];
          2'b01:   m[15:8]  = wdata[7:0];
          2'b10:   m[23:16] = wdata[7:0];
          default: m[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (off[1]) begin
          m[31:16] = wdata[15:0];
        end else begin
          m[15:0] = wdata[15:0];
        end
      end
      default: m = wdata;
    endcase
    return m;
  endfunction

  state_t        state_r;
  logic          req_ready_r;
  logic          resp_valid_r;
  logic [31:0]   resp_rdata_r;
  logic          resp_err_r;
  logic [31:0]   mem_addr_r;
  logic          mem_memread_r;
  logic          mem_memwrite_r;
  logic [31:0]   mem_wdata_r;

  logic          we_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic [1:0]    off_r;
  logic [31:0]   wdata_r;

  logic          size_err_s;
  logic          range_err_s;
  logic          req_err_s;
  logic [IDX_W-1:0] req_idx_s;
  logic          accept_s;

  // Alignment and size legality of the request currently offered.
  always_comb begin
    size_err_s = 1'b0;
    case (req_size)
      SIZE_B:  size_err_s = 1'b0;
      SIZE_H:  size_err_s = req_addr[0];
      SIZE_W:  size_err_s = (req_addr[1:0] != 2'b00);
      default: size_err_s = 1'b1;
    endcase
  end

`ifdef LSU_RANGE_CHECK_EN
  assign range_err_s = (req_addr[31:IDX_W+2] != '0);
`else
  logic unused_addr_hi_s;
  assign range_err_s      = 1'b0;
  assign unused_addr_hi_s = ^req_addr[31:IDX_W+2];
`endif

  assign req_err_s = size_err_s | range_err_s;
  assign req_idx_s = req_addr[IDX_W+1:2] & IDX_MASK[IDX_W-1:0];
  assign accept_s  = req_valid & req_ready_r;

  // Request/response sequencer; all interface outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      req_ready_r    <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_rdata_r   <= 32'h0000_0000;
      resp_err_r     <= 1'b0;
      mem_addr_r     <= 32'h0000_0000;
      mem_memread_r  <= 1'b0;
      mem_memwrite_r <= 1'b0;
      mem_wdata_r    <= 32'h0000_0000;
      we_r           <= 1'b0;
      size_r         <= 2'b00;
      uns_r          <= 1'b0;
      off_r          <= 2'b00;
      wdata_r        <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r        <= req_we;
            size_r      <= req_size;
            uns_r       <= req_unsigned;
            off_r       <= req_addr[1:0];
            wdata_r     <= req_wdata;
            req_ready_r <= 1'b0;
            if (req_err_s) begin
              // Illegal request: answer immediately, never touch memory.
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 32'h0000_0000;
            end else if (!req_we || (req_size != SIZE_W)) begin
              // Loads and sub-word stores both need the current word.
              state_r       <= READ;
              mem_memread_r <= 1'b1;
              mem_addr_r    <= {{(32-IDX_W){1'b0}}, req_idx_s};
            end else begin
              state_r        <= WRITE;
              mem_memwrite_r <= 1'b1;
              mem_addr_r     <= {{(32-IDX_W){1'b0}}, req_idx_s};
              mem_wdata_r    <= req_wdata;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        READ: begin
          mem_memread_r <= 1'b0;
          if (we_r) begin
            state_r        <= WRITE;
            mem_memwrite_r <= 1'b1;
            mem_wdata_r    <= merge_store(mem_rdata, wdata_r, off_r, size_r);
          end else begin
            state_r      <= RESP;
            resp_valid_r <= 1'b1;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= load_extend(mem_rdata, off_r, size_r, uns_r);
          end
        end
        WRITE: begin
          mem_memwrite_r <= 1'b0;
          state_r        <= RESP;
          resp_valid_r   <= 1'b1;
          resp_err_r     <= 1'b0;
          resp_rdata_r   <= 32'h0000_0000;
        end
        RESP: begin
          if (resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            req_ready_r  <= 1'b1;
          end else begin
            state_r      <= RESP;
          end
        end
        default: begin
          state_r        <= IDLE;
          req_ready_r    <= 1'b0;
          resp_valid_r   <= 1'b0;
          mem_memread_r  <= 1'b0;
          mem_memwrite_r <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_r;
  assign resp_valid   = resp_valid_r;
  assign resp_rdata   = resp_rdata_r;
  assign resp_err     = resp_err_r;
  assign mem_addr     = mem_addr_r;
  assign mem_memread  = mem_memread_r;
  assign mem_memwrite = mem_memwrite_r;
  assign mem_wdata    = mem_wdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:63];
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  int          both_cnt = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(64), .IDX_W(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:0]];

  // Word memory plus strobe monitor.
  always @(posedge clk) begin
    if (mem_memwrite) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
    if (mem_memread) rd_cnt <= rd_cnt + 1;
    if (mem_memread && mem_memwrite) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", {31'b0, resp_valid}, 32'd1);
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int lat;
    send(we, size, uns, addr, wdata);
    wait_resp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, exp_err});
    ack();
  endtask

  initial begin
    int rd0;
    int wr0;
    int lat;
    logic [31:0] held;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_strobes", {30'b0, mem_memread, mem_memwrite}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Word store then word load
    xfer("st_w", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("st_w_addr", last_wr_addr, 32'd4);
    chk("st_w_data", last_wr_data, 32'hDEADBEEF);
    xfer("ld_w", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    // Sub-word loads with extension
    xfer("st_w2", 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2);
    xfer("ld_bs12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 32'hFFFFFFFF, 1'b0, 2);
    xfer("ld_bu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 2);
    xfer("ld_hs12", 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0, 2);
    xfer("ld_bs11", 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 2);
    xfer("ld_hu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00007F01, 1'b0, 2);

    // Read-modify-write stores
    xfer("st_w3", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
    xfer("st_b11", 1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AA, 32'h0, 1'b0, 3);
    chk("st_b11_wdata", last_wr_data, 32'h1122AA44);
    xfer("ld_after_b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 2);
    xfer("st_h12", 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234BEEF, 32'h0, 1'b0, 3);
    chk("st_h12_mem", mem[4], 32'hBEEFAA44);

    // Error responses never touch memory
    rd0 = rd_cnt; wr0 = wr_cnt;
    xfer("err_w0e", 1'b0, 2'b10, 1'b0, 32'h0E, 32'h0, 32'h0, 1'b1, 1);
    xfer("err_h03", 1'b0, 2'b01, 1'b0, 32'h03, 32'h0, 32'h0, 1'b1, 1);
    xfer("err_sz3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 1);
    xfer("err_sth01", 1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF, 32'h0, 1'b1, 1);
    chk("err_no_reads", 32'(rd_cnt - rd0), 32'd0);
    chk("err_no_writes", 32'(wr_cnt - wr0), 32'd0);
    chk("err_mem4", mem[4], 32'hBEEFAA44);

    // Out-of-range store
    wr0 = wr_cnt;
`ifdef LSU_RANGE_CHECK_EN
    xfer("range", 1'b1, 2'b10, 1'b0, 32'h100, 32'h5555AAAA, 32'h0, 1'b1, 1);
    chk("range_no_write", 32'(wr_cnt - wr0), 32'd0);
`else
    xfer("range", 1'b1, 2'b10, 1'b0, 32'h100, 32'h5555AAAA, 32'h0, 1'b0, 2);
    chk("range_wr_addr", last_wr_addr, 32'd0);
    chk("range_mem0", mem[0], 32'h5555AAAA);
`endif

    // Response back-pressure
    send(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_resp(lat);
    chk("stall_lat", 32'(lat), 32'd2);
    held = resp_rdata;
    chk("stall_data", held, 32'hBEEFAA44);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", {31'b0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, 32'hBEEFAA44);
      chk("stall_req_ready", {31'b0, req_ready}, 32'd0);
    end
    ack();
    chk("stall_released", {31'b0, resp_valid}, 32'd0);

    // Reset during WRITE aborts the store
    send(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    chk("abort_in_write", {31'b0, mem_memwrite}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_we_drop", {31'b0, mem_memwrite}, 32'd0);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_mem4", mem[4], 32'hBEEFAA44);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    xfer("abort_ld", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hBEEFAA44, 1'b0, 2);

    chk("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts load/store requests from the core over a valid/ready handshake and sequences word-wide read and write accesses to data_memory. It performs byte/half/word extraction with sign or zero extension on loads. Sub-word stores use read-modify-write, because data_memory is word-only. It sits between the execute stage and data_memory.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the attached data memory (power of two)
IDX_W, 6, width of the word index; log2(MEM_WORDS)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts the response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal size, or out-of-range access
mem_addr  output  32  word index to data_memory; upper bits 0
mem_memread  output  1  read enable to data_memory
mem_memwrite  output  1  write enable to data_memory (sampled at posedge)
mem_wdata  output  32  write data to data_memory
mem_rdata  input  32  combinational read data from data_memory

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - req_ready=0 while reset is asserted; req_ready=1 from the first cycle after release.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_memread=0, mem_memwrite=0, mem_addr=0, mem_wdata=0.
  - Reset asserted mid-operation aborts the access. mem_memwrite drops combinationally with reset, so no partial write occurs.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch we/size/unsigned/addr/wdata.
  - Error check at acceptance. Error if: size=11; half with addr[0]=1; word with addr[1:0]≠00; out-of-range (see Optional Feature).
  - Error -> RESP with err=1, rdata=0, no memory access.
  - Load or sub-word store -> READ.
  - Word store -> WRITE.
- READ (1 cycle):
  - mem_memread=1, mem_addr=addr[IDX_W+1:2].
  - Capture mem_rdata at the clock edge.
  - Load: extract the lane selected by addr[1:0] (byte) or addr[1] (half), extend per req_unsigned, then -> RESP.
  - Sub-word store: merge req_wdata[7:0] or [15:0] into the captured word at the addressed lane, then -> WRITE.
- WRITE (1 cycle):
  - mem_memwrite=1, mem_addr=word index.
  - mem_wdata = merged word (sub-word) or req_wdata (word).
  - Then -> RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_ready.
  - On resp_valid & resp_ready -> IDLE.
  - req_ready=0 outside IDLE, so no new request is taken in the same cycle a response completes.
- Latency (accept edge to resp_valid):
  - Word load: 2 cycles.
  - Word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Memory strobes are 0 in every state except their own. mem_memread and mem_memwrite are never both 1.
- Byte lane k occupies bits [8k+7:8k] (little-endian). Half lane h occupies bits [16h+15:16h].

Optional Feature:
Macro LSU_RANGE_CHECK_EN.
- Defined: a request with req_addr[31:IDX_W+2] ≠ 0 is an error. It gets a 1-cycle error response and no memory access.
- Undefined: upper address bits are ignored. The word index wraps modulo MEM_WORDS, and no range error is raised.

Test Plan:
- Release reset, then store word 0xDEADBEEF to addr 0x10, then load word from 0x10 -> mem_memwrite pulse at mem_addr=4; load returns resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Memory word 4 = 0x80FF7F01; load byte signed at 0x12 -> 0xFFFFFFFF; load byte unsigned at 0x13 -> 0x00000080; load half signed at 0x12 -> 0xFFFF80FF.
- Memory word 4 = 0x11223344; store byte 0xAA to 0x11 -> READ then WRITE, mem_wdata=0x1122AA44; a later load word reads 0x1122AA44.
- Word load at 0x0E, half load at 0x03, and size=11 -> resp_err=1, resp_rdata=0, mem_memread and mem_memwrite stay 0, response 1 cycle after accept.
- Store word to 0x100 (index 64): with LSU_RANGE_CHECK_EN -> resp_err=1, no write; without it -> write lands at mem_addr=0, resp_err=0.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0. Assert reset during WRITE -> mem_memwrite falls immediately, memory unchanged, FSM returns to IDLE.
